// File: rtl/schommel_if.sv
// Actuator bus for the rocking-motion generator: amplitude/frequency levels in,
// step/direction/position stream and status out.
interface schommel_if;
  logic              A_dummy_unused_guard;
  logic [2:0]        A;
  logic [2:0]        F;
  logic              F0;
  logic              step;
  logic              dir;
  logic signed [5:0] pos;
  logic              busy;
  logic              done;

  modport master (
    output A, F, F0,
    input  step, dir, pos, busy, done
  );

  modport slave (
    input  A, F, F0,
    output step, dir, pos, busy, done
  );
endinterface

// File: rtl/schommel_gen.sv
// Rocking-motion generator. Swings a signed position symmetrically between
// -E and +E (E = STEP_PER_A * A), one step every (8 - F) prescaler ticks, and
// walks the cradle back to centre one step per tick once the swing stops.
module schommel_gen #(
  parameter int PRESC      = 1000,
  parameter int STEP_PER_A = 4
) (
  input  logic      clk,
  input  logic      reset,
  schommel_if.slave bus
);

  localparam int PW = $clog2(PRESC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_RETURN
  } state_t;

  // Swing extent for an amplitude level, as a 6-bit signed magnitude.
  function automatic logic signed [5:0] extent(input logic [2:0] a);
    int e;
    e = STEP_PER_A * int'(a);
    return e[5:0];
  endfunction

  state_t            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [2:0]        icnt_q, icnt_d;
  logic signed [5:0] pos_q, pos_d;
  logic              dir_q, dir_d;
  logic              step_q, step_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              tick;
  logic              stop;
  logic signed [5:0] ext;
  logic signed [5:0] neg_ext;

  assign tick    = (presc_q == PW'(PRESC - 1));
  assign stop    = bus.F0 | (bus.A == 3'd0);
  assign ext     = extent(bus.A);
  assign neg_ext = -ext;

  // Free-running base-tick prescaler; only reset stops it.
  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Next-state, interval counter and step generation.
  always_comb begin
    state_d = state_q;
    icnt_d  = icnt_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        icnt_d = 3'd0;
        if (!stop) begin
          state_d = S_UP;
        end
      end

      S_UP, S_DOWN: begin
        if (tick) begin
          if (icnt_q == 3'd0) begin
            // Reload uses the frequency level seen at this step, so a new F
            // only changes the spacing from the following interval on.
            step_d = 1'b1;
            icnt_d = 3'd7 - bus.F;
            if (state_q == S_UP) begin
              pos_d = pos_q + 6'sd1;
              dir_d = 1'b1;
            end else begin
              pos_d = pos_q - 6'sd1;
              dir_d = 1'b0;
            end
          end else begin
            icnt_d = icnt_q - 3'd1;
          end
        end
        // Stop wins over reversal. Reversal is checked every cycle against
        // the live extent, so a shrinking A turns the swing around at once.
        if (stop) begin
          state_d = S_RETURN;
        end else if (state_q == S_UP && pos_d >= ext) begin
          state_d = S_DOWN;
        end else if (state_q == S_DOWN && pos_d <= neg_ext) begin
          state_d = S_UP;
        end
      end

      S_RETURN: begin
        icnt_d = 3'd0;
        if (pos_q == 6'sd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (tick) begin
          step_d = 1'b1;
          if (pos_q > 6'sd0) begin
            pos_d = pos_q - 6'sd1;
            dir_d = 1'b0;
          end else begin
            pos_d = pos_q + 6'sd1;
            dir_d = 1'b1;
          end
          if (pos_d == 6'sd0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      icnt_q  <= 3'd0;
      pos_q   <= 6'sd0;
      dir_q   <= 1'b1;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      icnt_q  <= icnt_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.step = step_q;
  assign bus.dir  = dir_q;
  assign bus.pos  = pos_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_schommel_gen.sv
// Testbench for schommel_gen: directed scenarios with spec-derived constants
// plus randomized A/F/F0/reset sequences against a tick-level reference model.
module tb_schommel_gen;

  localparam int PRESC = 4;
  localparam int SPA   = 4;

  logic clk = 1'b0;
  logic reset;

  schommel_if bus();

  schommel_gen #(.PRESC(PRESC), .STEP_PER_A(SPA)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: mode 0 idle, 1 swinging, 2 returning.
  int m_mode, m_sign, m_pos, m_cyc, m_tidx, m_next;
  bit m_dir, m_step, m_done, m_first;

  task automatic adv();
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ($signed(bus.pos) > 28 || $signed(bus.pos) < -28) begin
      n_fail++;
      $display("FAIL pos_range: pos=%0d outside -28..28", $signed(bus.pos));
    end
  endtask

  task automatic do_reset(input int a, input int f, input bit f0);
    reset  = 1'b0;
    bus.A  = 3'(a);
    bus.F  = 3'(f);
    bus.F0 = f0;
    repeat (2) adv();
    reset = 1'b1;
  endtask

  task automatic wait_step(input string name, input int budget, output int gap);
    gap = 0;
    do begin
      adv();
      gap++;
    end while (bus.step !== 1'b1 && gap < budget);
    if (bus.step !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no step within %0d cycles", name, budget);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_sign = 1; m_pos = 0; m_cyc = 0; m_tidx = 0; m_next = 0;
    m_dir = 1'b1; m_step = 1'b0; m_done = 1'b0; m_first = 1'b0;
  endtask

  // One clock edge of the reference model: steps scheduled by absolute tick index.
  task automatic model_step(input bit rst_n, input int a, input int f, input bit f0);
    int e;
    bit s, tk;
    m_step = 1'b0;
    m_done = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tk = ((m_cyc % PRESC) == PRESC - 1);
    m_cyc++;
    e = SPA * a;
    s = f0 || (a == 0);
    case (m_mode)
      0: if (!s) begin m_mode = 1; m_sign = 1; m_first = 1'b1; end
      1: begin
        if (tk && (m_first || m_tidx == m_next)) begin
          m_pos += m_sign;
          m_dir = (m_sign > 0);
          m_step = 1'b1;
          m_next = m_tidx + 8 - f;
          m_first = 1'b0;
        end
        if (s) m_mode = 2;
        else if (m_sign > 0 && m_pos >= e) m_sign = -1;
        else if (m_sign < 0 && m_pos <= -e) m_sign = 1;
      end
      default: begin
        if (m_pos == 0) begin
          m_mode = 0; m_done = 1'b1;
        end else if (tk) begin
          m_dir = (m_pos < 0);
          m_pos += (m_pos < 0) ? 1 : -1;
          m_step = 1'b1;
          if (m_pos == 0) begin m_mode = 0; m_done = 1'b1; end
        end
      end
    endcase
    if (tk) m_tidx++;
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.A = 3'd5; bus.F = 3'd5; bus.F0 = 1'b0;
    repeat (3) adv();
    n_tests++; if (bus.pos !== 6'd0) begin n_fail++; $display("FAIL reset_pos: got %0d want 0", $signed(bus.pos)); end
    n_tests++; if (bus.step !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %b want 0", bus.step); end
    n_tests++; if (bus.dir !== 1'b1) begin n_fail++; $display("FAIL reset_dir: got %b want 1", bus.dir); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
  endtask

  task automatic test_basic_swing();
    int gap, exp_pos, d;
    bus.A = 3'd1; bus.F = 3'd7; bus.F0 = 1'b0; reset = 1'b1;
    adv();
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL swing_busy: got %b want 1", bus.busy); end
    exp_pos = 0; d = 1;
    for (int k = 0; k < 24; k++) begin
      wait_step("swing", 16, gap);
      exp_pos += d;
      n_tests++; if (gap != ((k == 0) ? PRESC - 1 : PRESC)) begin n_fail++; $display("FAIL swing_gap: step %0d got %0d cycles want %0d", k, gap, (k == 0) ? PRESC - 1 : PRESC); end
      n_tests++; if (bus.pos !== 6'(exp_pos)) begin n_fail++; $display("FAIL swing_pos: step %0d got %0d want %0d", k, $signed(bus.pos), exp_pos); end
      n_tests++; if (bus.dir !== (d > 0)) begin n_fail++; $display("FAIL swing_dir: step %0d got %b want %b", k, bus.dir, d > 0); end
      if (exp_pos >= 4) d = -1;
      else if (exp_pos <= -4) d = 1;
    end
  endtask

  task automatic test_freq_rate();
    int gap;
    do_reset(2, 5, 1'b0);
    wait_step("freq_first", 20, gap);
    for (int k = 0; k < 2; k++) begin
      wait_step("freq5", 30, gap);
      n_tests++; if (gap != 12) begin n_fail++; $display("FAIL freq5_gap: got %0d want 12", gap); end
    end
    repeat (4) adv();
    bus.F = 3'd6;
    wait_step("freq_change", 30, gap);
    n_tests++; if (gap + 4 != 12) begin n_fail++; $display("FAIL freq_pending_gap: got %0d want 12", gap + 4); end
    for (int k = 0; k < 2; k++) begin
      wait_step("freq6", 30, gap);
      n_tests++; if (gap != 8) begin n_fail++; $display("FAIL freq6_gap: got %0d want 8", gap); end
    end
  endtask

  task automatic test_stop_return();
    int gap, exp_pos;
    do_reset(1, 7, 1'b0);
    for (int k = 0; k < 3; k++) wait_step("stop_rise", 16, gap);
    n_tests++; if (bus.pos !== 6'd3) begin n_fail++; $display("FAIL stop_start_pos: got %0d want 3", $signed(bus.pos)); end
    bus.F0 = 1'b1; bus.F = 3'd0;
    adv();
    n_tests++; if (bus.busy !== 1'b1 || bus.step !== 1'b0) begin n_fail++; $display("FAIL stop_enter: busy=%b step=%b want busy=1 step=0", bus.busy, bus.step); end
    exp_pos = 3;
    for (int k = 0; k < 3; k++) begin
      wait_step("ret", 16, gap);
      exp_pos--;
      n_tests++; if (gap != ((k == 0) ? PRESC - 1 : PRESC)) begin n_fail++; $display("FAIL ret_gap: step %0d got %0d want %0d", k, gap, (k == 0) ? PRESC - 1 : PRESC); end
      n_tests++; if (bus.pos !== 6'(exp_pos)) begin n_fail++; $display("FAIL ret_pos: got %0d want %0d", $signed(bus.pos), exp_pos); end
      n_tests++; if (bus.dir !== 1'b0) begin n_fail++; $display("FAIL ret_dir: got %b want 0", bus.dir); end
      n_tests++; if (bus.done !== (exp_pos == 0) || bus.busy !== (exp_pos != 0)) begin n_fail++; $display("FAIL ret_status: done=%b busy=%b at pos %0d", bus.done, bus.busy, exp_pos); end
    end
    adv();
    n_tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL ret_done_width: done=%b busy=%b want 0 0", bus.done, bus.busy); end
    repeat (6) adv();
    n_tests++; if (bus.step !== 1'b0 || bus.pos !== 6'd0) begin n_fail++; $display("FAIL idle_quiet: step=%b pos=%0d want 0 0", bus.step, $signed(bus.pos)); end
  endtask

  task automatic test_shrink();
    int gap, exp_pos, d;
    do_reset(7, 7, 1'b0);
    for (int k = 0; k < 20; k++) wait_step("shrink_rise", 16, gap);
    n_tests++; if (bus.pos !== 6'd20) begin n_fail++; $display("FAIL shrink_start: got %0d want 20", $signed(bus.pos)); end
    bus.A = 3'd2;
    exp_pos = 20; d = -1;
    for (int k = 0; k < 60; k++) begin
      wait_step("shrink", 16, gap);
      exp_pos += d;
      n_tests++; if (bus.pos !== 6'(exp_pos)) begin n_fail++; $display("FAIL shrink_pos: step %0d got %0d want %0d", k, $signed(bus.pos), exp_pos); end
      n_tests++; if (gap != PRESC) begin n_fail++; $display("FAIL shrink_gap: step %0d got %0d want %0d", k, gap, PRESC); end
      if (exp_pos >= 8) d = -1;
      else if (exp_pos <= -8) d = 1;
    end
  endtask

  task automatic test_reset_mid();
    int gap;
    do_reset(2, 7, 1'b0);
    for (int k = 0; k < 21; k++) wait_step("mid_swing", 16, gap);
    n_tests++; if (bus.pos !== 6'(-5)) begin n_fail++; $display("FAIL mid_start: got %0d want -5", $signed(bus.pos)); end
    bus.F0 = 1'b1;
    adv();
    n_tests++; if (bus.pos !== 6'(-5) || bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_return: pos=%0d busy=%b want -5 1", $signed(bus.pos), bus.busy); end
    reset = 1'b0;
    adv();
    n_tests++; if (bus.pos !== 6'd0) begin n_fail++; $display("FAIL mid_pos: got %0d want 0", $signed(bus.pos)); end
    n_tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL mid_status: busy=%b done=%b want 0 0", bus.busy, bus.done); end
    n_tests++; if (bus.step !== 1'b0 || bus.dir !== 1'b1) begin n_fail++; $display("FAIL mid_outs: step=%b dir=%b want 0 1", bus.step, bus.dir); end
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      adv();
      n_tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_after: cycle %0d done=%b busy=%b", k, bus.done, bus.busy); end
    end
  endtask

  task automatic test_random();
    int a, f, len;
    bit f0, rn;
    model_reset();
    for (int seg = 0; seg < 40; seg++) begin
      a   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 7));
      f   = int'($urandom_range(0, 7));
      f0  = ($urandom_range(0, 7) == 0);
      rn  = ($urandom_range(0, 14) != 0) || (seg == 0);
      len = int'($urandom_range(20, 150));
      if (seg == 0) rn = 1'b0;
      bus.A = 3'(a); bus.F = 3'(f); bus.F0 = f0;
      for (int c = 0; c < len; c++) begin
        reset = (c == 0) ? rn : 1'b1;
        adv();
        model_step(reset, a, f, f0);
        n_tests++; if (bus.pos !== 6'(m_pos)) begin n_fail++; $display("FAIL rnd_pos: seg %0d cyc %0d got %0d want %0d", seg, c, $signed(bus.pos), m_pos); end
        n_tests++; if (bus.step !== m_step) begin n_fail++; $display("FAIL rnd_step: seg %0d cyc %0d got %b want %b", seg, c, bus.step, m_step); end
        n_tests++; if (bus.dir !== m_dir) begin n_fail++; $display("FAIL rnd_dir: seg %0d cyc %0d got %b want %b", seg, c, bus.dir, m_dir); end
        n_tests++; if (bus.busy !== (m_mode != 0)) begin n_fail++; $display("FAIL rnd_busy: seg %0d cyc %0d got %b want %b", seg, c, bus.busy, m_mode != 0); end
        n_tests++; if (bus.done !== m_done) begin n_fail++; $display("FAIL rnd_done: seg %0d cyc %0d got %b want %b", seg, c, bus.done, m_done); end
      end
    end
  endtask

  initial begin
    reset  = 1'b0;
    bus.A  = 3'd0;
    bus.F  = 3'd0;
    bus.F0 = 1'b0;
    test_reset();
    test_basic_swing();
    test_freq_rate();
    test_stop_return();
    test_shrink();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
